// File: rtl/irq_ctrl.sv
// Two-source rising-edge interrupt controller with a small register port and IDLE/REQ/ACTIVE FSM.
// Define IRQ_CTRL_SYNC_EN to pass irq_src through a 2-flop synchronizer (adds 2 cycles latency).
module irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  irq_src,
  input  logic        mstatus_mie,
  input  logic        stop_fetch,
  input  logic        mret_op,
  output logic [1:0]  interrupt,
  output logic        irq_active,
  output logic        active_id,
  input  logic        reg_en,
  input  logic        reg_we,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata
);

  typedef enum logic [1:0] {StIdle = 2'd0, StReq = 2'd1, StActive = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [1:0] s;
  logic [1:0] s_d_q;
  logic [1:0] rise;
  logic [1:0] pending_q, pending_d;
  logic [1:0] enable_q, enable_d;
  logic [1:0] clr;
  logic       req_id_q, req_id_d;
  logic       active_id_q, active_id_d;
  logic       wr, wr_enable, wr_pending, take;
  logic       unused_wdata;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = irq_src;
`endif

  assign unused_wdata = ^reg_wdata[31:2];

  assign rise       = s & ~s_d_q;
  assign wr         = reg_en & reg_we;
  assign wr_enable  = wr & (reg_addr == 4'h0);
  assign wr_pending = wr & (reg_addr == 4'h4);
  assign take       = (state_q == StReq) & mstatus_mie & ~stop_fetch;

  // A new edge on the same bit wins over both software clear and take.
  assign clr       = (wr_pending ? reg_wdata[1:0] : 2'b00) |
                     (take ? (2'b01 << req_id_q) : 2'b00);
  assign pending_d = (pending_q & ~clr) | rise;
  assign enable_d  = wr_enable ? reg_wdata[1:0] : enable_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      s_d_q       <= 2'b00;
      pending_q   <= 2'b00;
      enable_q    <= 2'b00;
      req_id_q    <= 1'b0;
      active_id_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_d_q       <= s;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      req_id_q    <= req_id_d;
      active_id_q <= active_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_id_d    = req_id_q;
    active_id_d = active_id_q;
    unique case (state_q)
      StIdle: begin
        if ((pending_q & enable_q) != 2'b00) begin
          state_d  = StReq;
          req_id_d = ~(pending_q[0] & enable_q[0]);
        end
      end
      StReq: begin
        if (take) begin
          state_d     = StActive;
          active_id_d = req_id_q;
        end else if (!(pending_q[req_id_q] & enable_q[req_id_q])) begin
          state_d = StIdle;
        end
      end
      StActive: begin
        if (mret_op && !stop_fetch) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    interrupt  = 2'b00;
    irq_active = 1'b0;
    if (state_q == StReq)    interrupt  = 2'b01 << req_id_q;
    if (state_q == StActive) irq_active = 1'b1;
  end

  assign active_id = active_id_q;

  always_comb begin
    reg_rdata = 32'h0;
    case (reg_addr)
      4'h0:    reg_rdata = {30'b0, enable_q};
      4'h4:    reg_rdata = {30'b0, pending_q};
      4'h8:    reg_rdata = {29'b0, active_id_q, state_q};
      4'hC:    reg_rdata = {30'b0, s};
      default: reg_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios then random traffic, checked against a
// behavioural model of pending sets, priority pick and service state.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  irq_src = 2'b00;
  logic        mstatus_mie = 1'b0, stop_fetch = 1'b0, mret_op = 1'b0;
  logic [1:0]  interrupt;
  logic        irq_active, active_id;
  logic        reg_en = 1'b0, reg_we = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .mstatus_mie(mstatus_mie),
    .stop_fetch (stop_fetch),
    .mret_op    (mret_op),
    .interrupt  (interrupt),
    .irq_active (irq_active),
    .active_id  (active_id),
    .reg_en     (reg_en),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata)
  );

  typedef struct {
    logic [1:0]  intr;
    logic        act;
    logic        aid;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0, n_pushed = 0, n_seen = 0;

  // Model: service state 0=idle, 1=requesting, 2=in service.
  int         m_state = 0, m_req = 0, m_act = 0;
  logic [1:0] m_pend = 2'b00, m_en = 2'b00, m_last = 2'b00;

  function automatic int lowest(input logic [1:0] v);
    for (int i = 0; i < 2; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  task automatic step(input logic rn, input logic [1:0] src, input logic mie, input logic sf,
                      input logic mret, input logic ren, input logic rwe,
                      input logic [3:0] addr, input logic [31:0] wd);
    logic [1:0] rising, clear, ready;
    exp_t e;
    @(negedge clk);
    reset_n = rn; irq_src = src; mstatus_mie = mie; stop_fetch = sf; mret_op = mret;
    reg_en = ren; reg_we = rwe; reg_addr = addr; reg_wdata = wd;
    if (!rn) begin
      m_state = 0; m_req = 0; m_act = 0; m_pend = 2'b00; m_en = 2'b00; m_last = 2'b00;
    end else begin
      rising = src & ~m_last;
      clear  = 2'b00;
      if (m_state == 0) begin
        ready = m_pend & m_en;
        if (ready != 2'b00) begin m_state = 1; m_req = lowest(ready); end
      end else if (m_state == 1) begin
        if (mie && !sf) begin
          m_state = 2; m_act = m_req; clear[m_req] = 1'b1;
        end else if (!(m_pend[m_req] && m_en[m_req])) begin
          m_state = 0;
        end
      end else if (mret && !sf) begin
        m_state = 0;
      end
      if (ren && rwe && addr == 4'h4) clear = clear | wd[1:0];
      if (ren && rwe && addr == 4'h0) m_en = wd[1:0];
      m_pend = (m_pend & ~clear) | rising;
      m_last = src;
    end
    e.intr  = (m_state == 1) ? ((m_req == 0) ? 2'b01 : 2'b10) : 2'b00;
    e.act   = (m_state == 2);
    e.aid   = (m_act == 1);
    case (addr)
      4'h0:    e.rdata = {30'b0, m_en};
      4'h4:    e.rdata = {30'b0, m_pend};
      4'h8:    e.rdata = {29'b0, e.aid, 2'(m_state)};
      4'hC:    e.rdata = {30'b0, src};
      default: e.rdata = 32'h0;
    endcase
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic rd(input logic [1:0] src, input logic mie, input logic sf, input logic mret,
                    input logic [3:0] addr);
    step(1'b1, src, mie, sf, mret, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic wr(input logic [1:0] src, input logic mie, input logic [3:0] addr,
                    input logic [31:0] wd);
    step(1'b1, src, mie, 1'b0, 1'b0, 1'b1, 1'b1, addr, wd);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_seen++;
        check("interrupt", {30'b0, interrupt}, {30'b0, e.intr});
        check("irq_active", {31'b0, irq_active}, {31'b0, e.act});
        check("active_id", {31'b0, active_id}, {31'b0, e.aid});
        check("reg_rdata", reg_rdata, e.rdata);
      end
    end
  end

  initial begin
    logic [1:0]  src;
    logic [3:0]  addr;
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 32'h0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 32'h0);
    // Single source service
    wr(2'b00, 1'b1, 4'h0, 32'h1);
    rd(2'b01, 1'b1, 1'b0, 1'b0, 4'h4);
    rd(2'b00, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b0, 1'b0, 4'h4);
    rd(2'b00, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b0, 1'b1, 4'h8);
    // Both sources at once, priority and deferred service
    wr(2'b00, 1'b0, 4'h0, 32'h3);
    rd(2'b11, 1'b0, 1'b0, 1'b0, 4'h4);
    for (int i = 0; i < 3; i++) rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b0, 1'b0, 1'b1, 4'h4);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b0, 1'b0, 1'b1, 4'h8);
    // Software clear while requesting
    wr(2'b00, 1'b0, 4'h0, 32'h1);
    rd(2'b01, 1'b0, 1'b0, 1'b0, 4'h4);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h8);
    wr(2'b00, 1'b0, 4'h4, 32'h1);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h4);
    // Stall blocks take and return
    rd(2'b01, 1'b1, 1'b1, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b1, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b1, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b00, 1'b1, 1'b1, 1'b1, 4'h8);
    rd(2'b00, 1'b1, 1'b0, 1'b1, 4'h8);
    // Edge coincident with take re-arms the same source
    rd(2'b01, 1'b0, 1'b0, 1'b0, 4'h4);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h8);
    rd(2'b01, 1'b1, 1'b0, 1'b0, 4'h4);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h4);
    rd(2'b00, 1'b0, 1'b0, 1'b1, 4'h8);
    rd(2'b00, 1'b0, 1'b0, 1'b0, 4'h8);
    // Reset while in service with a source held high
    wr(2'b00, 1'b0, 4'h0, 32'h3);
    rd(2'b10, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b10, 1'b1, 1'b0, 1'b0, 4'h8);
    rd(2'b10, 1'b1, 1'b0, 1'b0, 4'h8);
    step(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 32'h0);
    step(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 32'h0);
    rd(2'b10, 1'b1, 1'b0, 1'b0, 4'h4);
    rd(2'b10, 1'b1, 1'b0, 1'b0, 4'h0);
    rd(2'b10, 1'b1, 1'b0, 1'b0, 4'hC);
    // Random traffic
    src = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ 2'($urandom);
      case ($urandom_range(0, 4))
        0: addr = 4'h0;
        1: addr = 4'h4;
        2: addr = 4'h8;
        3: addr = 4'hC;
        default: addr = 4'($urandom);
      endcase
      step($urandom_range(0, 199) != 0, src, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           $urandom_range(0, 4) == 0, addr, $urandom);
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("outputs_seen", 32'(n_seen), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
